// File: rtl/tlul_pkg.sv
// TL-UL bus types shared by peripheral front-end stages.
// The payload typedefs carry every field of a beat except the handshake signals.
package tlul_pkg;

  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_DBW = TL_DW / 8;
  localparam int unsigned TL_SZW = 2;
  localparam int unsigned TL_AIW = 8;
  localparam int unsigned TL_DIW = 1;
  localparam int unsigned TL_AUW = 16;
  localparam int unsigned TL_DUW = 14;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic                a_valid;
    tl_a_op_e            a_opcode;
    logic [2:0]          a_param;
    logic [TL_SZW-1:0]   a_size;
    logic [TL_AIW-1:0]   a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_DBW-1:0]   a_mask;
    logic [TL_DW-1:0]    a_data;
    logic [TL_AUW-1:0]   a_user;
    logic                d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                d_valid;
    tl_d_op_e            d_opcode;
    logic [2:0]          d_param;
    logic [TL_SZW-1:0]   d_size;
    logic [TL_AIW-1:0]   d_source;
    logic [TL_DIW-1:0]   d_sink;
    logic [TL_DW-1:0]    d_data;
    logic [TL_DUW-1:0]   d_user;
    logic                d_error;
    logic                a_ready;
  } tl_d2h_t;

  typedef struct packed {
    tl_a_op_e            a_opcode;
    logic [2:0]          a_param;
    logic [TL_SZW-1:0]   a_size;
    logic [TL_AIW-1:0]   a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_DBW-1:0]   a_mask;
    logic [TL_DW-1:0]    a_data;
    logic [TL_AUW-1:0]   a_user;
  } tl_a_payload_t;

  typedef struct packed {
    tl_d_op_e            d_opcode;
    logic [2:0]          d_param;
    logic [TL_SZW-1:0]   d_size;
    logic [TL_AIW-1:0]   d_source;
    logic [TL_DIW-1:0]   d_sink;
    logic [TL_DW-1:0]    d_data;
    logic [TL_DUW-1:0]   d_user;
    logic                d_error;
  } tl_d_payload_t;

endpackage

// File: rtl/prim_fifo_sync_reg.sv
// Synchronous FIFO with registered storage and no fall-through; any depth 1..16.
// Pointers wrap at Depth-1 so non-power-of-2 depths waste no entries.
module prim_fifo_sync_reg #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  cnt_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push, pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  // Guard here so a careless caller can never overflow or underflow the count.
  assign push = push_i & ~full_o;
  assign pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (push) begin
        mem_q[wptr_q] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/tlul_fifo_stage.sv
// Registered TL-UL stage: one FIFO per channel so no ready/valid path crosses it
// combinationally. Fields pass through untouched.
module tlul_fifo_stage
  import tlul_pkg::*;
#(
  parameter int unsigned ReqDepth = 2,
  parameter int unsigned RspDepth = 2,
  localparam int unsigned ReqCntW = $clog2(ReqDepth + 1),
  localparam int unsigned RspCntW = $clog2(RspDepth + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  tl_h2d_t            tl_h_i,
  output tl_d2h_t            tl_h_o,
  output tl_h2d_t            tl_d_o,
  input  tl_d2h_t            tl_d_i,
  output logic [ReqCntW-1:0] req_cnt_o,
  output logic [RspCntW-1:0] rsp_cnt_o
);

  tl_a_payload_t req_wdata, req_rdata;
  tl_d_payload_t rsp_wdata, rsp_rdata;
  logic          req_full, req_empty, rsp_full, rsp_empty;
  logic          req_push, req_pop, rsp_push, rsp_pop;

  assign req_wdata = '{
    a_opcode:  tl_h_i.a_opcode,
    a_param:   tl_h_i.a_param,
    a_size:    tl_h_i.a_size,
    a_source:  tl_h_i.a_source,
    a_address: tl_h_i.a_address,
    a_mask:    tl_h_i.a_mask,
    a_data:    tl_h_i.a_data,
    a_user:    tl_h_i.a_user
  };

  assign rsp_wdata = '{
    d_opcode:  tl_d_i.d_opcode,
    d_param:   tl_d_i.d_param,
    d_size:    tl_d_i.d_size,
    d_source:  tl_d_i.d_source,
    d_sink:    tl_d_i.d_sink,
    d_data:    tl_d_i.d_data,
    d_user:    tl_d_i.d_user,
    d_error:   tl_d_i.d_error
  };

  assign req_push = tl_h_i.a_valid & ~req_full;
  assign req_pop  = ~req_empty & tl_d_i.a_ready;
  assign rsp_push = tl_d_i.d_valid & ~rsp_full;
  assign rsp_pop  = ~rsp_empty & tl_h_i.d_ready;

  prim_fifo_sync_reg #(
    .Width ($bits(tl_a_payload_t)),
    .Depth (ReqDepth)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (req_push),
    .wdata_i (req_wdata),
    .pop_i   (req_pop),
    .rdata_o (req_rdata),
    .full_o  (req_full),
    .empty_o (req_empty),
    .cnt_o   (req_cnt_o)
  );

  prim_fifo_sync_reg #(
    .Width ($bits(tl_d_payload_t)),
    .Depth (RspDepth)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rsp_push),
    .wdata_i (rsp_wdata),
    .pop_i   (rsp_pop),
    .rdata_o (rsp_rdata),
    .full_o  (rsp_full),
    .empty_o (rsp_empty),
    .cnt_o   (rsp_cnt_o)
  );

  always_comb begin
    tl_d_o           = '0;
    tl_d_o.a_valid   = ~req_empty;
    tl_d_o.a_opcode  = req_rdata.a_opcode;
    tl_d_o.a_param   = req_rdata.a_param;
    tl_d_o.a_size    = req_rdata.a_size;
    tl_d_o.a_source  = req_rdata.a_source;
    tl_d_o.a_address = req_rdata.a_address;
    tl_d_o.a_mask    = req_rdata.a_mask;
    tl_d_o.a_data    = req_rdata.a_data;
    tl_d_o.a_user    = req_rdata.a_user;
    tl_d_o.d_ready   = ~rsp_full;
  end

  always_comb begin
    tl_h_o          = '0;
    tl_h_o.d_valid  = ~rsp_empty;
    tl_h_o.d_opcode = rsp_rdata.d_opcode;
    tl_h_o.d_param  = rsp_rdata.d_param;
    tl_h_o.d_size   = rsp_rdata.d_size;
    tl_h_o.d_source = rsp_rdata.d_source;
    tl_h_o.d_sink   = rsp_rdata.d_sink;
    tl_h_o.d_data   = rsp_rdata.d_data;
    tl_h_o.d_user   = rsp_rdata.d_user;
    tl_h_o.d_error  = rsp_rdata.d_error;
    tl_h_o.a_ready  = ~req_full;
  end

endmodule

// File: doc/tlul_fifo_stage.md
# tlul_fifo_stage

Registered TL-UL buffering stage placed directly upstream of the register adapter in each peripheral. It decouples the crossbar-facing host port from the device port with one request FIFO on channel A and one response FIFO on channel D. This breaks every combinational ready/valid path between crossbar and register logic. It passes all TL-UL fields through unmodified and reports occupancy for debug.

## Interface
- `ReqDepth`, default 2: request FIFO entries; legal range 1..16, non-power-of-2 allowed.
- `RspDepth`, default 2: response FIFO entries; legal range 1..16.
- `clk_i`, input, 1: clock.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `tl_h_i`, input, `tl_h2d_t`: host-side request; the crossbar drives it.
- `tl_h_o`, output, `tl_d2h_t`: host-side response and `a_ready`.
- `tl_d_o`, output, `tl_h2d_t`: device-side request; it feeds the register adapter.
- `tl_d_i`, input, `tl_d2h_t`: device-side response and `a_ready`.
- `req_cnt_o`, output, `$clog2(ReqDepth+1)`: request FIFO occupancy.
- `rsp_cnt_o`, output, `$clog2(RspDepth+1)`: response FIFO occupancy.

## Operation
- **Request FIFO entry:** `{a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_user}`.
- **Response FIFO entry:** `{d_opcode, d_param, d_size, d_source, d_sink, d_data, d_user, d_error}`.
- **Channel A mapping:**
  - push when `tl_h_i.a_valid & tl_h_o.a_ready`.
  - `tl_h_o.a_ready = (req_cnt != ReqDepth)`.
  - `tl_d_o.a_valid = (req_cnt != 0)`.
  - `tl_d_o` A fields come from the head entry.
  - pop when `tl_d_o.a_valid & tl_d_i.a_ready`.
- **Channel D mapping:**
  - push when `tl_d_i.d_valid & tl_d_o.d_ready`.
  - `tl_d_o.d_ready = (rsp_cnt != RspDepth)`.
  - `tl_h_o.d_valid = (rsp_cnt != 0)`.
  - `tl_h_o` D fields come from the head entry.
  - pop when `tl_h_o.d_valid & tl_h_i.d_ready`.
- **Pointers:** write and read pointers wrap from Depth-1 to 0, not modulo 2^n.
- **Count update:**
  - push only: +1.
  - pop only: -1.
  - simultaneous push and pop: unchanged.
  - A push is never accepted when full.
  - A simultaneous push and pop while full cannot occur, because ready is deasserted whenever the FIFO is full.
- **No transformation:** the stage performs no error checking, no field modification and no reordering. Ordering is strict FIFO per channel.
- **Ready independence:** ready outputs depend only on the stage's own counts, never combinationally on the opposite side's ready or valid.
- **Reset:** asynchronous assertion, at any time including mid-burst, drops all buffered beats.
  - Counts and pointers go to 0.
  - Storage goes to 0.
  - `tl_d_o.a_valid` = 0 and `tl_h_o.d_valid` = 0.
  - `tl_h_o.a_ready` = 1 and `tl_d_o.d_ready` = 1.
  - All payload outputs are 0.
- **Payload when empty:** payload outputs show the head entry, which is stale or zero. Benches check payload only when valid is high.

## Timing
- **Latency:** one cycle per stage. A beat pushed at edge N is visible with valid high after edge N, i.e. in cycle N+1. There is no fall-through.
- **Throughput:** one beat per cycle per channel when Depth ≥ 2.
  - With Depth = 1, throughput is one beat every 2 cycles, because ready is low while the FIFO is full.
- **Round trip:** adds 2 cycles to a transaction (1 on A, 1 on D).
- **Occupancy outputs:** `req_cnt_o` and `rsp_cnt_o` are registered and update on the edge of the push or pop.

## Structure
- **Shared package:** `tlul_pkg` already provides `tl_h2d_t` and `tl_d2h_t`.
- **Package additions:** add the packed typedefs `tl_a_payload_t` and `tl_d_payload_t`, each the field list above without valid and ready, so other stages reuse them.
- **Sub-module:** one generic sub-module `prim_fifo_sync_reg`, with parameters `Width` and `Depth`, providing push/pop, full/empty, count, registered storage and no fall-through. Instantiate it twice.
- **Top-level logic:** the top-level is field packing and unpacking plus the valid/ready mapping.

## Test plan
- **Reset state:** assert `rst_ni` = 0 → `tl_h_o.a_ready` = 1, `tl_d_o.d_ready` = 1, both valids 0, both counts 0.
- **Single Get:** Get to address 0x10, `a_source` 5, device `a_ready` held 1.
  - `tl_d_o.a_valid` rises 1 cycle after acceptance with address 0x10.
  - Device answers AccessAckData with data 0xDEADBEEF; it reaches `tl_h_o` 1 cycle later with `d_source` 5.
- **Back-pressure to full:** ReqDepth = 2, device `a_ready` = 0, 3 PutFullData issued back-to-back.
  - First two accepted, `req_cnt_o` = 2, `tl_h_o.a_ready` = 0, third stalled.
  - Release `a_ready` → beats exit in order with data 0x1, 0x2, 0x3.
- **Streaming:** continuous stream of 8 requests with both sides always ready → one beat per cycle, count stays at 1, no bubbles.
- **Response back-pressure:** host `d_ready` = 0 while device returns 3 responses with RspDepth = 2.
  - `tl_d_o.d_ready` drops after 2 responses.
  - Order and `d_error` bits are preserved on release.
- **Mid-traffic reset:** `rst_ni` asserted with `req_cnt` = 2 and `rsp_cnt` = 1 → both counts 0 and both valids 0 immediately, asynchronously, and no stale beat appears after reset release.
